// File: rtl/mat_rand_pkg.sv
// mat_rand_pkg: shared defaults, FSM states and element type for the random-matrix path
package mat_rand_pkg;
  localparam int DEF_MAX_DIM = 5;
  localparam int DEF_DIM_W = 3;
  typedef enum logic [1:0] {IDLE, GEN, OUT, DONE} gen_state_e;
  typedef logic signed [7:0] elem_t;
endpackage

// File: rtl/rand_range_map.sv
// rand_range_map: scales a random byte into the inclusive signed range [val_min, val_min+span-1]
module rand_range_map
  import mat_rand_pkg::*;
(
  input  logic [7:0] lfsr_data,
  input  elem_t      val_min,
  input  logic [8:0] span,
  output elem_t      elem
);
  logic [8:0] scaled;
  assign scaled = 9'(({9'd0, lfsr_data} * {8'd0, span}) >> 8);
  assign elem = elem_t'({val_min[7], val_min} + scaled);
endmodule

// File: rtl/rand_matrix_gen.sv
// rand_matrix_gen: streams a rows x cols matrix of LFSR-derived values in row-major order
module rand_matrix_gen
  import mat_rand_pkg::*;
#(
  parameter int MAX_DIM = DEF_MAX_DIM,
  parameter int DIM_W = DEF_DIM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] rows,
  input  logic [DIM_W-1:0] cols,
  input  logic [7:0]       val_min,
  input  logic [7:0]       val_max,
  input  logic [7:0]       lfsr_data,
  output logic             lfsr_en,
  output logic             elem_valid,
  input  logic             elem_ready,
  output logic [7:0]       elem_data,
  output logic [DIM_W-1:0] elem_row,
  output logic [DIM_W-1:0] elem_col,
  output logic             elem_last,
  output logic             busy,
  output logic             done,
  output logic             err
);
  gen_state_e state, state_d;
  logic [DIM_W-1:0] rows_q, cols_q, row, col;
  elem_t vmin_q, elem;
  logic [8:0] span_q;
  logic req_ok, accept, hs;

  assign req_ok = rows != '0 && rows <= DIM_W'(MAX_DIM) && cols != '0 && cols <= DIM_W'(MAX_DIM)
                  && $signed(val_min) <= $signed(val_max);
  assign accept = state == IDLE && start && req_ok && !abort;
  assign hs = state == OUT && elem_ready && !abort;

  rand_range_map u_map (
    .lfsr_data(lfsr_data),
    .val_min  (vmin_q),
    .span     (span_q),
    .elem     (elem)
  );

  // next-state and state-decoded outputs; abort overrides every transition
  always_comb begin
    lfsr_en = state == GEN;
    elem_valid = state == OUT;
    busy = state != IDLE;
    done = state == DONE;
    state_d = abort ? IDLE :
              state == IDLE ? (accept ? GEN : IDLE) :
              state == GEN ? OUT :
              state == OUT ? (elem_ready ? (elem_last ? DONE : GEN) : OUT) : IDLE;
  end

  // state, latched config, position counters and registered element outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rows_q <= '0;
      cols_q <= '0;
      vmin_q <= '0;
      span_q <= '0;
      row <= '0;
      col <= '0;
      elem_data <= '0;
      elem_row <= '0;
      elem_col <= '0;
      elem_last <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      err <= state == IDLE && start && !abort && !req_ok;
      if (accept) begin
        rows_q <= rows;
        cols_q <= cols;
        vmin_q <= val_min;
        span_q <= 9'({val_max[7], val_max} - {val_min[7], val_min} + 9'd1);
        row <= '0;
        col <= '0;
      end
      if (state == GEN) begin
        elem_data <= elem;
        elem_row <= row;
        elem_col <= col;
        elem_last <= row == rows_q - DIM_W'(1) && col == cols_q - DIM_W'(1);
      end
      if (hs && !elem_last) begin
        col <= col == cols_q - DIM_W'(1) ? '0 : col + DIM_W'(1);
        row <= col == cols_q - DIM_W'(1) ? row + DIM_W'(1) : row;
      end
    end
  end
endmodule
